// File: rtl/data_lsu.sv
// data_lsu: byte/half/word load-store unit driving a word-addressed memory port with byte enables
module data_lsu #(
    parameter int ADDR_W  = 7,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_uns,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_re,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_busy
);
    typedef enum logic [2:0] {IDLE, RD_ISS, RD_WAIT, WR_ISS, WR_WAIT, DONE, ERR} state_t;
    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d, we_q, we_d;
    logic [1:0]        size_q, size_d, off_q, off_d;
    logic              uns_q, uns_d, ready_q, valid_q, err_q, re_q;
    logic [31:0]       rdata_q, rdata_d, wdata_q, wdata_d, shifted, ext;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              misaligned, timed_out, unused_addr;
    assign req_ready   = ready_q;
    assign resp_valid  = valid_q;
    assign resp_err    = err_q;
    assign resp_rdata  = rdata_q;
    assign mem_re      = re_q;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign unused_addr = ^req_addr[31:ADDR_W+2];
    always_comb begin
        misaligned = req_size == 2'd3 || (req_size == 2'd1 && req_addr[0]) ||
                     (req_size == 2'd2 && req_addr[1:0] != 2'd0);
        shifted    = mem_rdata >> {off_q, 3'b000};
        ext        = size_q == 2'd0 ? {{24{~uns_q & shifted[7]}}, shifted[7:0]}
                   : size_q == 2'd1 ? {{16{~uns_q & shifted[15]}}, shifted[15:0]} : shifted;
        // cnt_q counts WAIT cycles already spent, so this fires on the TIMEOUT-th one
        timed_out  = TIMEOUT != 0 && int'(cnt_q) + 1 >= TIMEOUT;
        state_d    = state_q;
        cnt_d      = cnt_q;
        size_d     = size_q;
        off_d      = off_q;
        uns_d      = uns_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = '0;
        we_d       = '0;
        case (state_q)
            IDLE: if (req_valid) begin
                size_d  = req_size;
                off_d   = req_addr[1:0];
                uns_d   = req_uns;
                addr_d  = req_addr[ADDR_W+1:2];
                wdata_d = req_size == 2'd0 ? {4{req_wdata[7:0]}}
                        : req_size == 2'd1 ? {2{req_wdata[15:0]}} : req_wdata;
                we_d    = misaligned || !req_we ? 4'd0
                        : req_size == 2'd0 ? 4'b0001 << req_addr[1:0]
                        : req_size == 2'd1 ? 4'b0011 << req_addr[1:0] : 4'hF;
                state_d = misaligned ? ERR : req_we ? WR_ISS : RD_ISS;
            end
            RD_ISS, WR_ISS: begin
                state_d = state_q == RD_ISS ? RD_WAIT : WR_WAIT;
                cnt_d   = '0;
            end
            RD_WAIT, WR_WAIT:
                if (!mem_busy) begin
                    state_d = DONE;
                    rdata_d = state_q == RD_WAIT ? ext : '0;
                end else if (timed_out) state_d = ERR;
                else cnt_d = cnt_q + {3'd0, cnt_q != 4'hF};
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            size_q  <= '0;
            off_q   <= '0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            re_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            off_q   <= off_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            ready_q <= state_d == IDLE;
            valid_q <= state_d == DONE || state_d == ERR;
            err_q   <= state_d == ERR;
            re_q    <= state_d == RD_ISS || state_d == RD_WAIT;
        end
    end
endmodule

// File: tb/tb_data_lsu.sv
// tb_data_lsu: directed vectors, corner sequences and random accesses against a byte-level memory model
module tb_data_lsu;
    localparam int ADDR_W = 7, TIMEOUT = 15;
    logic              clk = 1'b0, rst = 1'b0, req_valid = 1'b0, req_we = 1'b0, req_uns = 1'b0;
    logic [1:0]        req_size = 2'd0;
    logic [31:0]       req_addr = '0, req_wdata = '0;
    logic              req_ready, resp_valid, resp_err, mem_re, mem_busy;
    logic [31:0]       resp_rdata, mem_wdata, mem_rdata;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    always #5 clk = ~clk;
    data_lsu #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_uns(req_uns), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_re(mem_re),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_busy(mem_busy)
    );
    // adapter: registered busy, 2 cycles per read, 1 per write
    logic [31:0] seed_words [128];
    logic [31:0] mem [128];
    logic [1:0]  bcnt = 2'd0;
    logic        prev_re = 1'b0, loaded = 1'b0, hang = 1'b0;
    assign mem_busy  = bcnt != 2'd0 || hang;
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        prev_re <= mem_re;
        if (mem_re && !prev_re) bcnt <= 2'd2;
        else if (|mem_we) bcnt <= 2'd1;
        else if (bcnt != 2'd0) bcnt <= bcnt - 2'd1;
        if (!loaded) begin
            for (int i = 0; i < 128; i++) mem[i] <= seed_words[i];
            loaded <= 1'b1;
        end else for (int i = 0; i < 4; i++) if (mem_we[i]) mem[mem_addr][8*i+:8] <= mem_wdata[8*i+:8];
    end
    int n_chk = 0, n_fail = 0;
    logic [7:0] refb [512];
    typedef struct {
        logic we; logic [1:0] size; logic uns; logic [31:0] addr, wdata;
        logic e_err; logic [31:0] e_rdata; int e_lat; logic [3:0] e_we; logic [31:0] e_wd;
    } vec_t;
    typedef struct {
        int lat; logic err; logic [31:0] rdata; logic [3:0] we_val; int we_cnt;
        logic [31:0] wd; logic re_any; logic [6:0] a; int viol;
    } res_t;
    vec_t vecs[$];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    function automatic vec_t mk(int we, int size, int uns, logic [31:0] a, logic [31:0] wd,
                                int e, logic [31:0] rd, int lat, int wm, logic [31:0] ewd);
        vec_t v;
        v.we = 1'(we); v.size = 2'(size); v.uns = 1'(uns); v.addr = a; v.wdata = wd;
        v.e_err = 1'(e); v.e_rdata = rd; v.e_lat = lat; v.e_we = 4'(wm); v.e_wd = ewd;
        return v;
    endfunction
    // reference: byte-addressed memory, latency fixed by access kind
    task automatic model(inout vec_t v);
        int n, base;
        n = v.size == 2'd3 ? 1 : 1 << v.size;
        base = int'(v.addr[8:0]);
        v.e_err = v.size == 2'd3 || base % n != 0;
        v.e_rdata = '0; v.e_we = '0; v.e_wd = '0;
        v.e_lat = v.e_err ? 1 : v.we ? 4 : 5;
        if (!v.e_err && v.we) begin
            for (int i = 0; i < n; i++) begin
                refb[base+i] = v.wdata[8*i+:8];
                v.e_we[base%4+i] = 1'b1;
            end
            for (int k = 0; k < 4; k++) v.e_wd[8*k+:8] = v.wdata[8*(k%n)+:8];
        end else if (!v.e_err) begin
            for (int i = 0; i < n; i++) v.e_rdata = v.e_rdata | (32'(refb[base+i]) << (8*i));
            if (!v.uns && n < 4 && v.e_rdata[8*n-1]) v.e_rdata = v.e_rdata | (32'hFFFF_FFFF << (8*n));
        end
    endtask
    task automatic do_access(input vec_t v, output res_t r);
        int waited;
        waited = 0;
        r.lat = -1; r.err = 1'b0; r.rdata = '0; r.we_val = '0; r.we_cnt = 0;
        r.wd = '0; r.re_any = 1'b0; r.a = '0; r.viol = 0;
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        req_we = v.we; req_size = v.size; req_uns = v.uns; req_addr = v.addr; req_wdata = v.wdata;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (mem_re && |mem_we) r.viol++;
            if (k == 1) r.a = mem_addr;
            else if ((mem_re || |mem_we) && mem_addr != r.a) r.viol++;
            if (|mem_we) begin
                r.we_cnt++;
                r.we_val = mem_we;
                r.wd = mem_wdata;
            end
            if (mem_re) r.re_any = 1'b1;
            if (resp_valid) begin
                r.lat = k; r.err = resp_err; r.rdata = resp_rdata;
                break;
            end
        end
    endtask
    task automatic run_and_check(input string name, input vec_t v);
        res_t r;
        do_access(v, r);
        chk({name, ".lat"}, r.lat, v.e_lat);
        chk({name, ".err"}, 32'(r.err), 32'(v.e_err));
        chk({name, ".rdata"}, r.rdata, v.e_rdata);
        chk({name, ".we"}, 32'(r.we_cnt * 16 + int'(r.we_val)), 32'((v.e_we != 0 ? 16 : 0) + int'(v.e_we)));
        if (v.e_we != 0) chk({name, ".wdata"}, r.wd, v.e_wd);
        if (v.e_lat > 1) chk({name, ".addr"}, 32'(r.a), (v.addr >> 2) & 32'h7F);
        chk({name, ".re"}, 32'(r.re_any), 32'(!v.we && v.e_lat > 1));
        chk({name, ".proto"}, r.viol, 0);
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, required finish within 2 ms");
        $fatal(1);
    end
    initial begin
        vec_t v;
        for (int i = 0; i < 128; i++) begin
            seed_words[i] = i == 4 ? 32'h8001_7F00 : $urandom;
            for (int b = 0; b < 4; b++) refb[4*i+b] = seed_words[i][8*b+:8];
        end
        rst = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h13; req_wdata = 32'hAB;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("reset.ctl", 32'({req_ready, resp_valid, resp_err, mem_re, mem_we}), 32'h80);
            chk("reset.rdata", resp_rdata, 32'h0);
        end
        req_valid = 1'b0; rst = 1'b1;
        vecs.push_back(mk(0, 1, 0, 32'h12, 0, 0, 32'hFFFF_8001, 5, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h12, 0, 0, 32'h0000_8001, 5, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h11, 0, 0, 32'h0000_007F, 5, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h13, 0, 0, 32'hFFFF_FF80, 5, 0, 0));
        vecs.push_back(mk(0, 2, 0, 32'h10, 0, 0, 32'h8001_7F00, 5, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h13, 32'hAB, 0, 0, 4, 4'b1000, 32'hABAB_ABAB));
        vecs.push_back(mk(0, 2, 0, 32'h10, 0, 0, 32'hAB01_7F00, 5, 0, 0));
        vecs.push_back(mk(1, 1, 0, 32'h16, 32'h1234_BEEF, 0, 0, 4, 4'b1100, 32'hBEEF_BEEF));
        vecs.push_back(mk(0, 1, 1, 32'h16, 0, 0, 32'h0000_BEEF, 5, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h16, 0, 0, 32'hFFFF_BEEF, 5, 0, 0));
        vecs.push_back(mk(1, 2, 0, 32'h14, 32'hCAFE_F00D, 0, 0, 4, 4'hF, 32'hCAFE_F00D));
        vecs.push_back(mk(0, 0, 1, 32'h15, 0, 0, 32'h0000_00F0, 5, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h15, 0, 0, 32'hFFFF_FFF0, 5, 0, 0));
        vecs.push_back(mk(0, 2, 0, 32'h06, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 32'h01, 32'h1234, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 3, 0, 32'h20, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(1, 2, 0, 32'h22, 32'h55, 1, 0, 1, 0, 0));
        foreach (vecs[i]) begin
            v = vecs[i];
            model(v);
            run_and_check($sformatf("vec%0d", i), vecs[i]);
        end
        chk("b2b.ready_low", 32'(req_ready), 32'h0);
        @(negedge clk);
        chk("b2b.ready_back", 32'(req_ready), 32'h1);
        hang = 1'b1;
        run_and_check("timeout", mk(0, 2, 0, 32'h10, 0, 1, 0, TIMEOUT + 2, 0, 0));
        hang = 1'b0;
        v = mk(0, 1, 0, 32'h12, 0, 0, 0, 0, 0, 0);
        model(v);
        run_and_check("after_timeout", v);
        @(negedge clk);
        req_we = 1'b0; req_size = 2'd2; req_addr = 32'h10; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mid.re_before", 32'(mem_re), 32'h1);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid.after", 32'({req_ready, resp_valid, mem_re, mem_we}), 32'h40);
        rst = 1'b1;
        v = mk(1, 0, 0, 32'h21, 32'h5A, 0, 0, 0, 0, 0);
        model(v);
        run_and_check("post_rst_store", v);
        for (int i = 0; i < 80; i++) begin
            v = mk(int'($urandom_range(1)), int'($urandom_range(3)), int'($urandom_range(1)),
                   $urandom, $urandom, 0, 0, 0, 0, 0);
            if ($urandom_range(3) != 0 && v.size != 2'd3) v.addr = v.addr & ~((32'd1 << v.size) - 32'd1);
            model(v);
            run_and_check($sformatf("rnd%0d", i), v);
        end
        @(negedge clk);
        for (int i = 0; i < 128; i++)
            chk($sformatf("mem%0d", i), mem[i], {refb[4*i+3], refb[4*i+2], refb[4*i+1], refb[4*i]});
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
